// File: rtl/addr_seq_unit_pkg.sv
// addr_pkg: shared FSM states, lane indices, SFR addresses and opcodes for addr_seq_unit (ADDRU_ERR_TRAP_EN adds the TRAP state)
package addr_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_DEC, ST_IND, ST_SRC, ST_DST, ST_DONE
`ifdef ADDRU_ERR_TRAP_EN
    , ST_TRAP
`endif
  } state_t;
  localparam int SRC_CODE = 0, SRC_DATA = 1, SRC_XCODE = 2, SRC_XDATA = 3, SRC_ALU = 4, SRC_VT2 = 5, SRC_VT1 = 6;
  localparam int DST_DATA = 0, DST_XDATA = 1, DST_VT2 = 2, DST_VT1 = 3, DST_IR = 4, DST_REL = 5;
  localparam int SFR_P0 = 0, SFR_P1 = 1, SFR_P2 = 2, SFR_P3 = 3, SFR_PSW = 4, SFR_A = 5, SFR_B = 6;
  localparam logic [7:0] ADDR_P0 = 8'h80, ADDR_P1 = 8'h90, ADDR_P2 = 8'hA0, ADDR_P3 = 8'hB0;
  localparam logic [7:0] ADDR_PSW = 8'hD0, ADDR_A = 8'hE0, ADDR_B = 8'hF0;
  localparam logic [7:0] SFR_ADDR [7] = '{ADDR_P0, ADDR_P1, ADDR_P2, ADDR_P3, ADDR_PSW, ADDR_A, ADDR_B};
  localparam logic [7:0] OP_MOV_A_DIR = 8'hE5, OP_MOV_DIR_A = 8'hF5, OP_MOV_C_BIT = 8'hA2, OP_MOV_BIT_C = 8'h92;
endpackage

// File: rtl/addr_seq_unit_if.sv
// addr_seq_unit_if: IR/operand request in (start, IR, direct, psw_rs, ind_ptr), sequencing status and lane enables out; master = CU fetch side, slave = sequencer
interface addr_seq_unit_if #(parameter int SFR_NUM = 7, SRC_BASE = 7, DST_BASE = 6);
  logic start, busy, done, Bb, Rn_ext, err;
  logic [7:0] IR, direct, ind_ptr, position, rn_addr;
  logic [1:0] psw_rs;
  logic [SRC_BASE+SFR_NUM-1:0] Addr_src;
  logic [DST_BASE+SFR_NUM-1:0] Addr_dst;
  modport master (output start, IR, direct, psw_rs, ind_ptr,
                  input busy, done, Bb, position, Rn_ext, rn_addr, Addr_src, Addr_dst, err);
  modport slave (input start, IR, direct, psw_rs, ind_ptr,
                 output busy, done, Bb, position, Rn_ext, rn_addr, Addr_src, Addr_dst, err);
endinterface

// File: rtl/addr_seq_unit_sfr_lane_dec.sv
// sfr_lane_dec: 8-bit address (addr) to one-hot SFR lanes (lanes, P0 at MSB) plus any-lane hit flag (hit)
module sfr_lane_dec import addr_pkg::*; #(parameter int SFR_NUM = 7) (
  input  logic [7:0]         addr,
  output logic [SFR_NUM-1:0] lanes,
  output logic               hit
);
  for (genvar i = 0; i < SFR_NUM; i++) begin : g_lane
    assign lanes[SFR_NUM-1-i] = addr == SFR_ADDR[i];
  end
  assign hit = |lanes;
endmodule

// File: rtl/addr_seq_unit.sv
// addr_seq_unit: multi-cycle operand-address sequencer; ports clk, rst_n (async low) and bus (slave: start/IR/direct/psw_rs/ind_ptr in, busy/done/Bb/position/Rn_ext/rn_addr/Addr_src/Addr_dst/err out); ADDRU_ERR_TRAP_EN makes errors sticky in TRAP
module addr_seq_unit import addr_pkg::*; #(
  parameter int RN_BANKS = 4, SFR_NUM = 7, SRC_BASE = 7, DST_BASE = 6
) (
  input logic clk,
  input logic rst_n,
  addr_seq_unit_if.slave bus
);
  localparam int SW = SRC_BASE + SFR_NUM, DW = DST_BASE + SFR_NUM;
  state_t state, state_nx;
  logic [7:0] ir_q, dir_q, ptr_q, byte_addr, bit_mask, mem_addr, reg_a, src_a, dst_a;
  logic [1:0] bank_q;
  logic [SFR_NUM-1:0] src_lanes, dst_lanes;
  logic [SW-1:0] src_vec;
  logic [DW-1:0] dst_vec;
  logic accept, rn, ri, is_bit, valid, mem_is_src, data_mem, src_hit, dst_hit, err_c, ok, mem_ph, oth_ph, seq, trap;
  assign accept = bus.start & (state == ST_IDLE | state == ST_DONE);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ir_q <= '0;
      dir_q <= '0;
      bank_q <= '0;
      ptr_q <= '0;
    end else begin
      if (accept) begin
        ir_q <= bus.IR;
        dir_q <= bus.direct;
        bank_q <= bus.psw_rs & 2'(RN_BANKS - 1);
      end
      if (state == ST_IND) ptr_q <= bus.ind_ptr;
    end
  assign rn = ir_q[7:5] == 3'b111 & ir_q[3];
  assign ri = ir_q[7:5] == 3'b111 & ir_q[3:1] == 3'b011;
  assign is_bit = ir_q == OP_MOV_C_BIT | ir_q == OP_MOV_BIT_C;
  assign valid = rn | ri | is_bit | ir_q == OP_MOV_A_DIR | ir_q == OP_MOV_DIR_A;
  // every supported move with IR[4]=0 reads memory and writes A or C; IR[4]=1 is the reverse
  assign mem_is_src = ~ir_q[4];
  assign byte_addr = !is_bit ? dir_q : dir_q[7] ? {dir_q[7:3], 3'b000} : 8'h20 + {4'h0, dir_q[6:3]};
  assign bit_mask = 8'h01 << dir_q[2:0];
  assign data_mem = rn | ri | ~byte_addr[7];
  assign mem_addr = ri ? ptr_q : rn ? {3'b000, bank_q, ir_q[2:0]} : byte_addr;
  // the register side is the accumulator, or PSW (carry) for bit moves; decoding it through the SFR map keeps one-hot lanes uniform
  assign reg_a = is_bit ? ADDR_PSW : ADDR_A;
  assign src_a = mem_is_src ? byte_addr : reg_a;
  assign dst_a = mem_is_src ? reg_a : byte_addr;
  sfr_lane_dec #(.SFR_NUM(SFR_NUM)) u_src_dec (.addr(src_a), .lanes(src_lanes), .hit(src_hit));
  sfr_lane_dec #(.SFR_NUM(SFR_NUM)) u_dst_dec (.addr(dst_a), .lanes(dst_lanes), .hit(dst_hit));
  assign src_vec = mem_is_src & data_mem ? SW'(1) << SRC_DATA : {src_lanes, {SRC_BASE{1'b0}}};
  assign dst_vec = !mem_is_src & data_mem ? DW'(1) << DST_DATA : {dst_lanes, {DST_BASE{1'b0}}};
  assign err_c = ~valid | ~(data_mem | (mem_is_src ? src_hit : dst_hit)) | ~(mem_is_src ? dst_hit : src_hit);
  assign ok = ~err_c;
  assign mem_ph = (state == ST_SRC & mem_is_src) | (state == ST_DST & ~mem_is_src);
  assign oth_ph = (state == ST_SRC & ~mem_is_src) | (state == ST_DST & mem_is_src);
  assign seq = state inside {ST_DEC, ST_IND, ST_SRC, ST_DST};
`ifdef ADDRU_ERR_TRAP_EN
  assign trap = state == ST_TRAP;
`else
  assign trap = 1'b0;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: state_nx = accept ? ST_DEC : ST_IDLE;
      ST_DEC:  state_nx = ri ? ST_IND : ST_SRC;
      ST_IND:  state_nx = ST_SRC;
      ST_SRC:  state_nx = ST_DST;
`ifdef ADDRU_ERR_TRAP_EN
      ST_DST:  state_nx = err_c ? ST_TRAP : ST_DONE;
`else
      ST_DST:  state_nx = ST_DONE;
`endif
      ST_DONE: state_nx = accept ? ST_DEC : ST_IDLE;
      default: state_nx = state;
    endcase
  end
  always_comb begin
    bus.busy = seq | trap;
    bus.done = state == ST_DONE;
    bus.err = (state == ST_DONE & err_c) | trap;
    bus.Bb = seq & ~is_bit;
    bus.Addr_src = state == ST_IND ? SW'(1) << SRC_DATA : state == ST_SRC & ok ? src_vec : '0;
    bus.Addr_dst = state == ST_DST & ok ? dst_vec : '0;
    bus.Rn_ext = state == ST_IND | (mem_ph & ok & (rn | ri));
    bus.rn_addr = state == ST_IND ? {3'b000, bank_q, 2'b00, ir_q[0]} : mem_ph & ok & data_mem ? mem_addr : 8'h00;
    bus.position = !(ok & is_bit) ? 8'h00 : mem_ph ? bit_mask : oth_ph ? 8'h80 : 8'h00;
  end
endmodule

// File: tb/tb_addr_seq_unit.sv
// tb_addr_seq_unit: directed table-driven bench for addr_seq_unit plus hand sequences for reset, back-to-back and error handling
module tb_addr_seq_unit;
  logic clk, rst_n;
  int checks = 0, failures = 0;
  addr_seq_unit_if #(.SFR_NUM(7), .SRC_BASE(7), .DST_BASE(6)) bus ();
  addr_seq_unit_if #(.SFR_NUM(7), .SRC_BASE(7), .DST_BASE(6)) bus2 ();
  addr_seq_unit #(.RN_BANKS(4), .SFR_NUM(7), .SRC_BASE(7), .DST_BASE(6)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  addr_seq_unit #(.RN_BANKS(2), .SFR_NUM(7), .SRC_BASE(7), .DST_BASE(6)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  assign bus2.start = bus.start;
  assign bus2.IR = bus.IR;
  assign bus2.direct = bus.direct;
  assign bus2.psw_rs = bus.psw_rs;
  assign bus2.ind_ptr = bus.ind_ptr;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] ir, dir; logic [1:0] rs; logic [7:0] ptr; int lat; logic [7:0] ind_rn;
    logic [13:0] src; logic [12:0] dst;
    logic [7:0] rn_src, rn_dst, rn2_src, rn2_dst, pos_src, pos_dst; logic bb;
  } vec_t;
  vec_t tbl [13];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] all_out(input int unused);
    return {bus.busy, bus.done, bus.Bb, bus.Rn_ext, bus.err, bus.position, bus.rn_addr} |
           {bus.Addr_src, bus.Addr_dst};
  endfunction

  task automatic issue(input logic [7:0] ir, input logic [7:0] dir, input logic [1:0] rs, input logic [7:0] ptr);
    bus.IR = ir;
    bus.direct = dir;
    bus.psw_rs = rs;
    bus.ind_ptr = ptr;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
  endtask

  task automatic run_vec(input int n, input vec_t v);
    bit got = 0;
    issue(v.ir, v.dir, v.rs, v.ptr);
    for (int k = 1; k <= 8 && !got; k++) begin
      if (k == 1) chk($sformatf("v%0d busy_dec", n), bus.busy, 1);
      if (v.lat == 5 && k == 2) chk($sformatf("v%0d ind_rn", n), {bus.Rn_ext, bus.Addr_src, bus.rn_addr}, {1'b1, 14'h0002, v.ind_rn});
      if (k == v.lat - 2) begin
        chk($sformatf("v%0d src", n), bus.Addr_src, v.src);
        chk($sformatf("v%0d rn_src", n), bus.rn_addr, v.rn_src);
        chk($sformatf("v%0d rn2_src", n), bus2.rn_addr, v.rn2_src);
        chk($sformatf("v%0d pos_src", n), bus.position, v.pos_src);
        chk($sformatf("v%0d bb", n), bus.Bb, v.bb);
      end
      if (k == v.lat - 1) begin
        chk($sformatf("v%0d dst", n), bus.Addr_dst, v.dst);
        chk($sformatf("v%0d rn_dst", n), bus.rn_addr, v.rn_dst);
        chk($sformatf("v%0d rn2_dst", n), bus2.rn_addr, v.rn2_dst);
        chk($sformatf("v%0d pos_dst", n), bus.position, v.pos_dst);
      end
      if (bus.done) begin
        got = 1;
        chk($sformatf("v%0d latency", n), k, v.lat);
        chk($sformatf("v%0d err_busy_done", n), {bus.err, bus.busy}, 2'b00);
      end else tick;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL v%0d timeout: got no done expected done", n);
    end
    tick;
  endtask

  task automatic run_err(input logic [7:0] ir, input logic [7:0] dir);
    logic [26:0] en = '0;
    issue(ir, dir, 2'd0, 8'h00);
    for (int k = 1; k <= 3; k++) begin
      en |= {bus.Addr_src, bus.Addr_dst};
      tick;
    end
    chk($sformatf("err %h/%h enables", ir, dir), en, 0);
`ifdef ADDRU_ERR_TRAP_EN
    chk($sformatf("err %h/%h trap", ir, dir), {bus.err, bus.busy, bus.done}, 3'b110);
    issue(8'hE5, 8'h30, 2'd0, 8'h00);
    tick;
    tick;
    chk($sformatf("err %h/%h trap_hold", ir, dir), {bus.err, bus.busy, bus.done, bus.Addr_src}, {3'b110, 14'h0});
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    chk($sformatf("err %h/%h trap_reset", ir, dir), {bus.err, bus.busy}, 2'b00);
`else
    chk($sformatf("err %h/%h done", ir, dir), {bus.err, bus.busy, bus.done}, 3'b101);
    tick;
    chk($sformatf("err %h/%h pulse", ir, dir), {bus.err, bus.done}, 2'b00);
`endif
  endtask

  initial begin
    tbl[0]  = '{8'hE5, 8'h30, 2'd0, 8'h00, 4, 8'h00, 14'h0002, 13'h0080, 8'h30, 8'h00, 8'h30, 8'h00, 8'h00, 8'h00, 1'b1};
    tbl[1]  = '{8'hE5, 8'hF0, 2'd0, 8'h00, 4, 8'h00, 14'h0080, 13'h0080, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1};
    tbl[2]  = '{8'hEA, 8'h00, 2'd1, 8'h00, 4, 8'h00, 14'h0002, 13'h0080, 8'h0A, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00, 1'b1};
    tbl[3]  = '{8'hE7, 8'h00, 2'd2, 8'h45, 5, 8'h11, 14'h0002, 13'h0080, 8'h45, 8'h00, 8'h45, 8'h00, 8'h00, 8'h00, 1'b1};
    tbl[4]  = '{8'hF5, 8'h90, 2'd0, 8'h00, 4, 8'h00, 14'h0100, 13'h0800, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1};
    tbl[5]  = '{8'hF5, 8'h7F, 2'd0, 8'h00, 4, 8'h00, 14'h0100, 13'h0001, 8'h00, 8'h7F, 8'h00, 8'h7F, 8'h00, 8'h00, 1'b1};
    tbl[6]  = '{8'hFC, 8'h00, 2'd3, 8'h00, 4, 8'h00, 14'h0100, 13'h0001, 8'h00, 8'h1C, 8'h00, 8'h0C, 8'h00, 8'h00, 1'b1};
    tbl[7]  = '{8'hF6, 8'h00, 2'd1, 8'h8A, 5, 8'h08, 14'h0100, 13'h0001, 8'h00, 8'h8A, 8'h00, 8'h8A, 8'h00, 8'h00, 1'b1};
    tbl[8]  = '{8'hA2, 8'h0B, 2'd0, 8'h00, 4, 8'h00, 14'h0002, 13'h0100, 8'h21, 8'h00, 8'h21, 8'h00, 8'h08, 8'h80, 1'b0};
    tbl[9]  = '{8'hA2, 8'hE3, 2'd0, 8'h00, 4, 8'h00, 14'h0100, 13'h0100, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08, 8'h80, 1'b0};
    tbl[10] = '{8'h92, 8'h7F, 2'd0, 8'h00, 4, 8'h00, 14'h0200, 13'h0001, 8'h00, 8'h2F, 8'h00, 8'h2F, 8'h80, 8'h80, 1'b0};
    tbl[11] = '{8'h92, 8'hD5, 2'd0, 8'h00, 4, 8'h00, 14'h0200, 13'h0100, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'h20, 1'b0};
    tbl[12] = '{8'hFF, 8'h00, 2'd3, 8'h00, 4, 8'h00, 14'h0100, 13'h0001, 8'h00, 8'h1F, 8'h00, 8'h0F, 8'h00, 8'h00, 1'b1};
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.IR = '0;
    bus.direct = '0;
    bus.psw_rs = '0;
    bus.ind_ptr = '0;
    tick;
    tick;
    chk("reset outputs", all_out(0), 0);
    rst_n = 1'b1;
    tick;
    chk("idle outputs", all_out(0), 0);
    issue(8'hE7, 8'h00, 2'd2, 8'h45);
    tick;
    chk("pre-reset ind", {bus.busy, bus.Rn_ext}, 2'b11);
    #2 rst_n = 1'b0;
    #1 chk("async reset outputs", all_out(0), 0);
    tick;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("post-reset idle c%0d", k), {bus.busy, bus.done}, 2'b00);
      tick;
    end
    for (int i = 0; i < 13; i++) run_vec(i, tbl[i]);
    issue(8'hE5, 8'h30, 2'd0, 8'h00);
    tick;
    tick;
    tick;
    chk("b2b done1", bus.done, 1);
    issue(8'hEB, 8'h00, 2'd1, 8'h00);
    chk("b2b dec", {bus.busy, bus.done}, 2'b10);
    tick;
    chk("b2b src", {bus.Addr_src, bus.rn_addr, bus.done}, {14'h0002, 8'h0B, 1'b0});
    tick;
    chk("b2b dst", {bus.Addr_dst, bus.done}, {13'h0080, 1'b0});
    tick;
    chk("b2b done2", bus.done, 1);
    tick;
    run_err(8'hF5, 8'h99);
    run_err(8'hE5, 8'h83);
    run_err(8'h00, 8'h10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
